// File: rtl/hazard_pkg.sv
// Shared types and constants for the load-use hazard scoreboard.
// Holds register-address types, bitmap helpers and the default in-flight load limit.
package hazard_pkg;

  localparam int REG_ADDR_W          = 5;
  localparam int NUM_REGS            = 32;
  localparam int CNT_W               = 4;
  localparam int MAX_OUTSTANDING_DEF = 4;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [NUM_REGS-1:0]   reg_mask_t;

  // One-hot mask for a register; x0 never produces a bit because it is hard-wired zero.
  function automatic reg_mask_t reg_onehot(input logic en, input reg_addr_t addr);
    reg_mask_t mask;
    mask = '0;
    if (en && (addr != '0)) mask[addr] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/hazard_pending_table.sv
// Per-register pending bitmap for in-flight loads, with set, write-back clear and
// flush clear ports plus two combinational lookup ports for the ID source operands.
module hazard_pending_table
  import hazard_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_reset,
  input  logic      i_set_en,
  input  reg_addr_t i_set_addr,
  input  logic      i_clr_en,
  input  reg_addr_t i_clr_addr,
  input  logic      i_flush_en,
  input  reg_addr_t i_flush_addr,
  input  reg_addr_t i_lookup_a_addr,
  input  reg_addr_t i_lookup_b_addr,
  output logic      o_lookup_a_hit,
  output logic      o_lookup_b_hit,
  output reg_mask_t o_pending
);

  reg_mask_t r_pending;
  reg_mask_t w_set_mask;
  reg_mask_t w_kill_mask;
  reg_mask_t w_pending_next;

  // NOTE: every signal driven here is assigned on every path, so no latch is inferred.
  always_comb begin
    w_set_mask     = reg_onehot(i_set_en, i_set_addr);
    w_kill_mask    = reg_onehot(i_clr_en, i_clr_addr) | reg_onehot(i_flush_en, i_flush_addr);
    // Set is applied after the clears: a newer load to the same rd owns the bit.
    w_pending_next = (r_pending & ~w_kill_mask) | w_set_mask;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_pending <= '0;
    else         r_pending <= w_pending_next;
  end

  assign o_lookup_a_hit = r_pending[i_lookup_a_addr];
  assign o_lookup_b_hit = r_pending[i_lookup_b_addr];
  assign o_pending      = r_pending;

endmodule

// File: rtl/hazard_scoreboard.sv
// Load-use hazard scoreboard: tracks in-flight load destinations and stalls ID on RAW
// or capacity hazards. Optional macro HAZARD_WB_BYPASS_EN releases the stall in the write-back cycle.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [4:0]          i_rs1_addr,
  input  logic [4:0]          i_rs2_addr,
  input  logic                i_rs1_used,
  input  logic                i_rs2_used,
  input  logic                i_id_is_load,
  input  logic                i_issue_valid,
  input  logic                i_issue_is_load,
  input  logic [4:0]          i_issue_rd_addr,
  input  logic                i_flush,
  input  logic                i_ld_done,
  input  logic [4:0]          i_ld_done_rd_addr,
  output logic                o_stall,
  output logic [3:0]          o_outstanding,
  output logic [NUM_REGS-1:0] o_pending,
  output logic                o_err
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic [CNT_W-1:0] r_count;
  logic             r_ex_load_v;
  reg_addr_t        r_ex_rd;
  logic             r_err;

  reg_mask_t        w_pending;
  logic             w_issue_load;
  logic             w_done_hit;
  logic             w_done_ok;
  logic             w_flush_dec;
  logic             w_rs1_hit;
  logic             w_rs2_hit;
  logic             w_rs1_byp;
  logic             w_rs2_byp;
  logic             w_raw_hazard;
  logic             w_cap_hazard;
  logic [CNT_W:0]   w_count_up;
  logic [1:0]       w_count_dn;
  logic [CNT_W:0]   w_count_diff;
  logic [CNT_W-1:0] w_count_next;

  assign w_issue_load = i_issue_valid & i_issue_is_load;
  assign w_done_hit   = w_pending[i_ld_done_rd_addr];
  // x0 loads are counted without a bitmap bit, so their completion only needs a nonzero count.
  assign w_done_ok    = i_ld_done & (r_count != '0) &
                        ((i_ld_done_rd_addr == '0) | w_done_hit);
  assign w_flush_dec  = i_flush & r_ex_load_v;

  hazard_pending_table u_pending_table (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_set_en        (w_issue_load),
    .i_set_addr      (i_issue_rd_addr),
    .i_clr_en        (w_done_ok),
    .i_clr_addr      (i_ld_done_rd_addr),
    .i_flush_en      (w_flush_dec),
    .i_flush_addr    (r_ex_rd),
    .i_lookup_a_addr (i_rs1_addr),
    .i_lookup_b_addr (i_rs2_addr),
    .o_lookup_a_hit  (w_rs1_hit),
    .o_lookup_b_hit  (w_rs2_hit),
    .o_pending       (w_pending)
  );

`ifdef HAZARD_WB_BYPASS_EN
  assign w_rs1_byp = i_ld_done & (i_ld_done_rd_addr == i_rs1_addr);
  assign w_rs2_byp = i_ld_done & (i_ld_done_rd_addr == i_rs2_addr);
`else
  assign w_rs1_byp = 1'b0;
  assign w_rs2_byp = 1'b0;
`endif

  assign w_raw_hazard = (i_rs1_used & (i_rs1_addr != '0) & w_rs1_hit & ~w_rs1_byp) |
                        (i_rs2_used & (i_rs2_addr != '0) & w_rs2_hit & ~w_rs2_byp);
  assign w_cap_hazard = i_id_is_load & (r_count == MAX_CNT);

  // Net counter change this cycle, saturating at both 0 and MAX_OUTSTANDING.
  always_comb begin
    w_count_up   = {1'b0, r_count} + {{CNT_W{1'b0}}, w_issue_load};
    w_count_dn   = {1'b0, w_done_ok} + {1'b0, w_flush_dec};
    w_count_diff = '0;
    w_count_next = r_count;
    if (w_count_up < {{(CNT_W-1){1'b0}}, w_count_dn}) begin
      w_count_next = '0;
    end else begin
      w_count_diff = w_count_up - {{(CNT_W-1){1'b0}}, w_count_dn};
      if (w_count_diff > {1'b0, MAX_CNT}) w_count_next = MAX_CNT;
      else                                w_count_next = w_count_diff[CNT_W-1:0];
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_count     <= '0;
      r_ex_load_v <= 1'b0;
      r_ex_rd     <= '0;
      r_err       <= 1'b0;
    end else begin
      r_count     <= w_count_next;
      r_ex_load_v <= w_issue_load;
      r_ex_rd     <= i_issue_rd_addr;
      if (i_ld_done && !w_done_ok) r_err <= 1'b1;
    end
  end

  assign o_stall       = w_raw_hazard | w_cap_hazard;
  assign o_outstanding = r_count;
  assign o_pending     = w_pending;
  assign o_err         = r_err;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed load-use scenarios followed by
// randomized pipeline traffic, compared against a behavioural scoreboard model.
module tb_hazard_scoreboard;

  localparam int MAX_OUT = 4;
`ifdef HAZARD_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [4:0]  rs1, rs2;
  logic        rs1_used, rs2_used, id_is_load;
  logic        issue_valid, issue_is_load;
  logic [4:0]  issue_rd;
  logic        flush, ld_done;
  logic [4:0]  ld_rd;
  logic        o_stall;
  logic [3:0]  o_outstanding;
  logic [31:0] o_pending;
  logic        o_err;

  hazard_scoreboard #(.MAX_OUTSTANDING(MAX_OUT)) dut (
    .i_clk             (clk),
    .i_reset           (rst),
    .i_rs1_addr        (rs1),
    .i_rs2_addr        (rs2),
    .i_rs1_used        (rs1_used),
    .i_rs2_used        (rs2_used),
    .i_id_is_load      (id_is_load),
    .i_issue_valid     (issue_valid),
    .i_issue_is_load   (issue_is_load),
    .i_issue_rd_addr   (issue_rd),
    .i_flush           (flush),
    .i_ld_done         (ld_done),
    .i_ld_done_rd_addr (ld_rd),
    .o_stall           (o_stall),
    .o_outstanding     (o_outstanding),
    .o_pending         (o_pending),
    .o_err             (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pending set of registers, count of live loads, the load in EX,
  // the sticky error and a FIFO of loads that have reached MEM/WB.
  bit [31:0] m_pend;
  int        m_cnt;
  bit        m_ex_v;
  int        m_ex_rd;
  bit        m_err;
  int        q[$];
  int        total;
  int        bad;
  string     phase;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  function automatic bit m_raw(input logic used, input logic [4:0] rs);
    if (!used || rs == 5'd0 || !m_pend[rs]) return 1'b0;
    if (BYP && ld_done && ld_rd == rs) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_stall();
    return m_raw(rs1_used, rs1) || m_raw(rs2_used, rs2) || (id_is_load && m_cnt == MAX_OUT);
  endfunction

  function automatic bit rd_busy(input int rd);
    if (rd == 0) return 1'b0;
    if (m_pend[rd] || (m_ex_v && m_ex_rd == rd)) return 1'b1;
    foreach (q[i]) if (q[i] == rd) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_cnt = 0; m_ex_v = 1'b0; m_ex_rd = 0; m_err = 1'b0;
    q.delete();
  endtask

  task automatic model_step();
    bit issue_ld, done_ok, fl;
    int n;
    issue_ld = issue_valid && issue_is_load;
    done_ok  = ld_done && m_cnt > 0 && (ld_rd == 5'd0 || m_pend[ld_rd]);
    fl       = flush && m_ex_v;
    if (ld_done && !done_ok) m_err = 1'b1;
    if (done_ok) m_pend[ld_rd] = 1'b0;
    if (fl) m_pend[m_ex_rd] = 1'b0;
    if (issue_ld) m_pend[issue_rd] = 1'b1;
    m_pend[0] = 1'b0;
    n = m_cnt + int'(issue_ld) - int'(done_ok) - int'(fl);
    m_cnt = (n < 0) ? 0 : (n > MAX_OUT) ? MAX_OUT : n;
    if (m_ex_v && !fl) q.push_back(m_ex_rd);
    m_ex_v  = issue_ld;
    m_ex_rd = int'(issue_rd);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".stall"}, {31'd0, o_stall}, {31'd0, m_stall()});
    check({tag, ".pend"}, o_pending, m_pend);
    check({tag, ".cnt"}, {28'd0, o_outstanding}, m_cnt);
    check({tag, ".err"}, {31'd0, o_err}, {31'd0, m_err});
  endtask

  task automatic idle();
    rs1 = '0; rs2 = '0; rs1_used = 1'b0; rs2_used = 1'b0; id_is_load = 1'b0;
    issue_valid = 1'b0; issue_is_load = 1'b0; issue_rd = '0;
    flush = 1'b0; ld_done = 1'b0; ld_rd = '0;
  endtask

  task automatic issue_load(input logic [4:0] rd);
    issue_valid = 1'b1; issue_is_load = 1'b1; issue_rd = rd;
  endtask

  // One pipeline cycle: compare mid-cycle, then advance the model on the rising edge.
  task automatic tick();
    @(negedge clk);
    check_all("cyc");
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    #2;
    model_reset();
    check_all("rst");
    check("rst_zero", {o_pending[31:1], o_stall, o_outstanding, o_err}, 38'd0 >> 6);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0; bad = 0; phase = "reset";
    idle();
    rst = 1'b1;
    model_reset();
    do_reset();

    phase = "raw_x5";
    idle(); issue_load(5'd5); tick();
    idle(); rs1 = 5'd5; rs1_used = 1'b1; #1;
    check("stall", {31'd0, o_stall}, 32'd1);
    check("pend5", {31'd0, o_pending[5]}, 32'd1);
    tick();
    ld_done = 1'b1; ld_rd = 5'd5; #1;
    check("stall_wb", {31'd0, o_stall}, {31'd0, !BYP});
    tick();
    ld_done = 1'b0; #1;
    check("release", {31'd0, o_stall}, 32'd0);
    tick();

    phase = "load_x0";
    idle(); issue_load(5'd0); tick();
    idle(); rs1 = 5'd0; rs1_used = 1'b1; #1;
    check("stall", {31'd0, o_stall}, 32'd0);
    check("cnt", {28'd0, o_outstanding}, 32'd1);
    tick();
    idle(); ld_done = 1'b1; ld_rd = 5'd0; tick();
    idle(); #1;
    check("cnt_after", {28'd0, o_outstanding}, 32'd0);
    check("err", {31'd0, o_err}, 32'd0);
    tick();

    phase = "capacity";
    for (int i = 1; i <= 4; i++) begin
      idle(); issue_load(5'(i)); tick();
    end
    idle(); id_is_load = 1'b1; rs1 = 5'd6; rs1_used = 1'b1; #1;
    check("stall", {31'd0, o_stall}, 32'd1);
    check("cnt", {28'd0, o_outstanding}, 32'd4);
    tick(); tick();
    ld_done = 1'b1; ld_rd = 5'd1; #1;
    check("stall_done", {31'd0, o_stall}, 32'd1);
    tick();
    ld_done = 1'b0; #1;
    check("release", {31'd0, o_stall}, 32'd0);
    check("cnt3", {28'd0, o_outstanding}, 32'd3);
    tick();
    for (int i = 2; i <= 4; i++) begin
      idle(); ld_done = 1'b1; ld_rd = 5'(i); tick();
    end

    phase = "flush_x7";
    idle(); issue_load(5'd7); tick();
    idle(); flush = 1'b1; tick();
    idle(); rs1 = 5'd7; rs1_used = 1'b1; #1;
    check("pend7", {31'd0, o_pending[7]}, 32'd0);
    check("cnt", {28'd0, o_outstanding}, 32'd0);
    check("stall", {31'd0, o_stall}, 32'd0);
    tick();

    phase = "same_x9";
    idle(); issue_load(5'd9); tick();
    idle(); tick();
    idle(); ld_done = 1'b1; ld_rd = 5'd9; issue_load(5'd9); tick();
    idle(); #1;
    check("pend9", {31'd0, o_pending[9]}, 32'd1);
    check("cnt", {28'd0, o_outstanding}, 32'd1);
    tick();
    idle(); ld_done = 1'b1; ld_rd = 5'd9; tick();
    idle(); tick();

    phase = "err_empty";
    idle(); ld_done = 1'b1; ld_rd = 5'd3; tick();
    idle(); #1;
    check("err", {31'd0, o_err}, 32'd1);
    tick(); tick();
    check("err_sticky", {31'd0, o_err}, 32'd1);
    do_reset();
    check("err_cleared", {31'd0, o_err}, 32'd0);

    phase = "mid_reset";
    idle(); issue_load(5'd10); tick();
    idle(); tick();
    do_reset();
    idle(); ld_done = 1'b1; ld_rd = 5'd10; tick();
    idle(); #1;
    check("err", {31'd0, o_err}, 32'd1);
    tick();
    do_reset();

    phase = "random";
    for (int c = 0; c < 400; c++) begin
      int cand;
      idle();
      rs1 = 5'($urandom_range(0, 7)); rs1_used = 1'($urandom);
      rs2 = 5'($urandom_range(0, 7)); rs2_used = 1'($urandom);
      id_is_load = ($urandom_range(0, 1) == 1);
      if (q.size() > 0 && $urandom_range(0, 2) == 0) begin
        ld_done = 1'b1;
        ld_rd   = 5'(q.pop_front());
      end else begin
        ld_rd = 5'($urandom_range(0, 31));
      end
      flush = m_ex_v ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 9) == 0);
      cand = $urandom_range(0, 7);
      issue_is_load = id_is_load;
      issue_rd = 5'(cand);
      issue_valid = !m_stall() && ($urandom_range(0, 3) != 0) &&
                    !(id_is_load && rd_busy(cand));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Load-use hazard scoreboard for the five-stage RISC-V pipeline. It tracks destination registers of loads that have issued but not yet written back, and it stalls the ID stage when a source operand depends on an in-flight load. Loads are the only case the forwarding control cannot cover. The block sits beside the forwarding control: it watches the producer side (issue, write-back, flush) and drives the pipeline stall line.

## Interface
- `MAX_OUTSTANDING`, default 4: maximum in-flight loads; legal range 1..15.
- `i_clk`  in  1  pipeline clock; all state updates on rising edge.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_rs1_addr` / `i_rs2_addr`  in  5  ID-stage source addresses.
- `i_rs1_used` / `i_rs2_used`  in  1  the ID instruction reads rs1 / rs2.
- `i_id_is_load`  in  1  the ID instruction is a load.
- `i_issue_valid`  in  1  the ID instruction advances to EX this cycle; it is low whenever `o_stall` = 1.
- `i_issue_is_load`  in  1  the issuing instruction is a load.
- `i_issue_rd_addr`  in  5  destination of the issuing instruction.
- `i_flush`  in  1  kill the instruction currently in EX (branch redirect).
- `i_ld_done`  in  1  load data written back this cycle.
- `i_ld_done_rd_addr`  in  5  destination of the completing load.
- `o_stall`  out  1  hold IF/ID and insert a bubble into EX.
- `o_outstanding`  out  4  number of in-flight loads.
- `o_pending`  out  32  per-register pending bitmap; bit 0 is always 0.
- `o_err`  out  1  sticky protocol error.

## Operation
- State: the pending bitmap, the outstanding counter, an EX tracker (`ex_load_v`, `ex_rd`) and the sticky error bit.
- Set: `i_issue_valid` & `i_issue_is_load` & rd != 0 sets `pending[rd]` and increments the counter. rd = 0 loads are counted but never set a pending bit.
- Clear: `i_ld_done` with `pending[rd]` = 1 clears the bit and decrements the counter.
- Same-cycle set and clear of the same rd: set wins; the newer load owns the bit. The counter stays unchanged.
- The EX tracker loads `ex_load_v` <= `i_issue_valid` & `i_issue_is_load` and `ex_rd` <= `i_issue_rd_addr` every cycle.
- `i_flush` with `ex_load_v` = 1 clears `pending[ex_rd]` and decrements the counter. A flush does not affect loads that are already in MEM or WB.
- RAW hazard: (`i_rs1_used` & rs1 != 0 & `pending[rs1]`) or the same condition on rs2.
- Capacity hazard: `i_id_is_load` & the counter equals `MAX_OUTSTANDING`.
- `o_stall` = RAW hazard or capacity hazard. It is combinational from registered state plus the ID inputs.
- Errors: `i_ld_done` while the counter is 0, or on a non-pending rd other than x0, sets `o_err`. The event is otherwise ignored. `o_err` clears only on reset.
- Arithmetic: the counter saturates at 0 and at `MAX_OUTSTANDING`. It never wraps.

## Timing
- Reset (asynchronous, immediate): bitmap = 0, counter = 0, `ex_load_v` = 0, `o_err` = 0, `o_stall` = 0.
- A load issued in cycle N sets its pending bit at edge N+1. A dependent instruction in ID in cycle N+1 stalls.
- A write-back in cycle M clears the bit at edge M+1. ID is released in cycle M+1; the operand arrives via WB forwarding or the register-file read.
- A flush in cycle N takes effect at edge N+1.
- Reset asserted mid-operation discards all in-flight state. Any later `i_ld_done` for pre-reset loads raises `o_err`.

## Configuration
- `HAZARD_WB_BYPASS_EN` defined: the RAW hazard is masked when `i_ld_done` is high and `i_ld_done_rd_addr` equals the stalled rs in the same cycle. The stall releases one cycle earlier; the register file must be write-first.
- Not defined: a stall persists until the bit is cleared, i.e. it releases in cycle M+1 as described under Timing.

## Structure
- Shared package `hazard_pkg` holds `REG_ADDR_W` = 5, `NUM_REGS` = 32, `typedef logic [4:0] reg_addr_t` and the default `MAX_OUTSTANDING`.
- One sub-module, `hazard_pending_table`: the bitmap with set/clear/flush-clear ports and two combinational lookup ports.

## Test plan
- Load x5 issues; next cycle ID uses rs1 = x5 -> `o_stall` = 1 and `o_pending[5]` = 1. `ld_done` x5 -> stall drops the next cycle (same cycle with the bypass macro).
- Load x0 issues, then ID uses rs1 = x0 -> `o_stall` = 0 and `o_outstanding` = 1.
- Four loads to x1..x4 with `MAX_OUTSTANDING` = 4; ID holds a load to x6 -> `o_stall` = 1 until the first `ld_done`.
- Load x7 issues, then `i_flush` the next cycle -> `o_pending[7]` = 0, `o_outstanding` = 0, no stall on x7.
- Same cycle: `ld_done` x9 and a new load to x9 issues -> `o_pending[9]` stays 1, counter unchanged.
- `ld_done` x3 with an empty scoreboard -> `o_err` = 1 and stays 1. `i_reset` pulse -> all outputs 0.
